// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
// Datapath <-> memory handshake bundle (MAR/MDR side of the memory port).
//   read, write   : request strobes from the datapath; levels held until mem_done
//   address       : word address from MAR
//   data_in       : write data from MDR
//   data_out      : read data, valid in the mem_done cycle
//   mem_done      : one-cycle completion pulse
//   busy          : high from request accept through the mem_done cycle
//   proto_err     : sticky handshake error flag
// Modports: master = datapath, slave = memory responder.
// ----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  mem_done;
    logic                  busy;
    logic                  proto_err;

    modport master (
        output read, write, address, data_in,
        input  data_out, mem_done, busy, proto_err
    );

    modport slave (
        input  read, write, address, data_in,
        output data_out, mem_done, busy, proto_err
    );
endinterface

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Word-addressed synchronous memory answering the datapath's MAR/MDR port
// with a programmable number of wait states and a mem_done pulse.
// Ports:
//   clk      : system clock, all state changes on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : mem_responder_if slave modport (strobes, address, data,
//              data_out, mem_done, busy, proto_err)
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1      // legal range 0..15
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RELEASE
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_op_wr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_proto_err;

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    logic                  w_strobe_held;
    logic                  w_mem_we;

    // The strobe belonging to the accepted operation; dropping it mid-wait
    // abandons the access.
    assign w_strobe_held = r_op_wr ? bus.write : bus.read;
    assign w_mem_we      = (r_state == S_ACCESS) && r_op_wr;

    // NOTE: the memory array has no reset; clearing it would turn a RAM into
    // a huge flop bank. Reset aborts an access because r_state drops to IDLE
    // asynchronously, so w_mem_we cannot fire on the next edge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_op_wr     <= 1'b0;
            r_data_out  <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.read && bus.write) begin
                        // Ambiguous request: accept nothing, wait for release.
                        r_proto_err <= 1'b1;
                        r_state     <= S_RELEASE;
                    end else if (bus.read || bus.write) begin
                        r_addr  <= bus.address;
                        r_data  <= bus.data_in;
                        r_op_wr <= bus.write;
                        r_cnt   <= LP_WAIT;
                        r_busy  <= 1'b1;
                        r_state <= (LP_WAIT != 4'd0) ? S_WAIT : S_ACCESS;
                    end
                end

                S_WAIT: begin
                    if (!w_strobe_held) begin
                        r_proto_err <= 1'b1;
                        r_busy      <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_cnt   <= '0;
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_ACCESS: begin
                    if (!r_op_wr) begin
                        r_data_out <= r_mem[r_addr];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_RELEASE;
                end

                S_RELEASE: begin
                    // mem_done and busy last for the entry cycle only.
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (!bus.read && !bus.write) begin
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.mem_done  = r_done;
    assign bus.busy      = r_busy;
    assign bus.proto_err = r_proto_err;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed synchronous memory that answers the datapath's MAR/MDR memory interface.
- The datapath issues single-word read/write strobes. This block holds off for a programmable number of wait states, completes the access and pulses mem_done.
- It replaces the zero-latency memory model so the control unit can be built and exercised against real wait-state handshakes.

Parameters:
- ADDR_WIDTH, 9, word-address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width.
- WAIT_STATES, 1, extra cycles between request accept and completion; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- read  input  1  read request strobe from the datapath; level, held until mem_done.
- write  input  1  write request strobe from the datapath; level, held until mem_done.
- address  input  ADDR_WIDTH  word address, driven from MAR.
- data_in  input  DATA_WIDTH  write data, driven from MDR.
- data_out  output  DATA_WIDTH  read data, captured by MDR when mem_done=1.
- mem_done  output  1  one-cycle completion pulse.
- busy  output  1  high from request accept through the mem_done cycle.
- proto_err  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, data_out=0, mem_done=0, busy=0, proto_err=0, wait counter=0.
  - Memory array contents are not reset.
  - Reset mid-access aborts the access with no write performed and no mem_done.
- States: IDLE, WAIT, ACCESS, RELEASE.
- IDLE:
  - On a rising edge with exactly one of read/write=1: latch address, data_in and op; load counter=WAIT_STATES; busy=1.
  - Next state is WAIT if WAIT_STATES>0, else ACCESS.
  - read=write=1 sampled in IDLE: set proto_err, accept nothing, go to RELEASE.
- WAIT:
  - Decrement the counter each cycle; move to ACCESS when the counter reaches 1.
  - If the latched strobe drops before completion: abandon the access (no write), set proto_err, go to IDLE, busy=0.
- ACCESS (one cycle):
  - Write: mem[addr_latched] <= data_latched.
  - Read: data_out <= mem[addr_latched].
  - Assert mem_done=1 on the following cycle, together with a transition to RELEASE.
  - data_out is valid in the mem_done cycle and holds until the next completed read.
  - Writes do not alter data_out.
- RELEASE:
  - mem_done=1 for the entry cycle only, then 0; busy drops with mem_done.
  - Wait until read=0 and write=0 are both sampled, then go to IDLE.
  - A strobe held high never re-triggers an access; each access needs a low-then-high strobe.
- Latency: request sampled at edge N, mem_done high in the cycle after edge N+WAIT_STATES+1. With WAIT_STATES=1, mem_done is seen 3 edges after the request.
- Address/data changes after accept are ignored (latched values are used).
- Read of a never-written location returns the array's initial value; the bench preloads it and must not depend on X.
- Back-to-back: minimum request period is WAIT_STATES+3 cycles (IDLE accept, WAIT(s), ACCESS, RELEASE with strobe low).

Test Plan:
- Reset, then preload mem[0x085]=0x0000_00AB; read=1 address=0x085 held until done, WAIT_STATES=1 -> mem_done one cycle exactly 3 edges after request; data_out=0x0000_00AB; busy high 3 cycles; proto_err=0.
- write=1 address=0x0BA data_in=0xDEAD_BEEF, then read 0x0BA -> second access returns 0xDEAD_BEEF; data_out unchanged (0x0000_00AB) during and after the write's mem_done.
- read held high for 10 cycles after mem_done -> exactly one mem_done pulse; a fresh read after one low cycle completes normally.
- read=write=1 in IDLE -> proto_err=1, no mem_done, memory unchanged; proto_err stays 1 through later good accesses until reset_n pulses low.
- write to 0x010 with reset_n asserted low in the WAIT cycle -> all outputs 0 immediately (async); subsequent read of 0x010 returns its preloaded value, not the aborted write data.
- Rebuild with WAIT_STATES=0 and WAIT_STATES=4 -> mem_done after 2 and 6 edges respectively; read data correct at both.
